// File: rtl/mfp_reset_seq.sv
// Staged reset sequencer for mfp_sys: board reset, PLL lock, cold/software/watchdog requests.
// Define MFP_RST_WDT_EN to build in the RUN-state watchdog (cause 11).
module mfp_reset_seq #(
  parameter int HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int PERIPH_TO_CPU = 8,
  parameter int WDT_CYCLES    = 2**24
) (
  input  logic       SI_ClkIn,
  input  logic       SI_Reset_N,
  input  logic       pll_locked,
  input  logic       cold_req_n,
  input  logic       sw_req,
  input  logic       wdt_kick,
  output logic       periph_reset_n,
  output logic       cpu_reset_n,
  output logic       cold_reset_n,
  output logic [1:0] rst_cause,
  output logic       lock_timeout,
  output logic       seq_done
);

  localparam int HL_MAX  = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX = (HL_MAX > PERIPH_TO_CPU) ? HL_MAX : PERIPH_TO_CPU;
  localparam int CW      = $clog2(CNT_MAX);

  typedef enum logic [2:0] {
    RST_HOLD,
    WAIT_LOCK,
    REL_PERIPH,
    REL_CPU,
    RUN
  } state_t;

  state_t        state;
  logic [CW-1:0] counter;
  logic [CW-1:0] cnt_inc;
  logic [1:0]    pll_sync;
  logic [1:0]    cold_sync;
  logic          pll_locked_s;
  logic          cold_req_s;
  logic          cold_hit;
  logic          wdt_hit;
  logic          req_any;
  logic [1:0]    req_cause;

  // The cold synchroniser resets to the idle (high) level so power-up is not seen as a cold request.
  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      pll_sync  <= '0;
      cold_sync <= '1;
    end else begin
      pll_sync  <= {pll_sync[0], pll_locked};
      cold_sync <= {cold_sync[0], cold_req_n};
    end
  end

  assign pll_locked_s = pll_sync[1];
  assign cold_req_s   = cold_sync[1];
  assign cold_hit     = !cold_req_s;
  assign cnt_inc      = (counter == '1) ? counter : counter + 1'b1;

`ifdef MFP_RST_WDT_EN
  localparam int WW = $clog2(WDT_CYCLES);
  logic [WW-1:0] wdt_cnt;

  // Held at the reload value outside RUN, so it restarts on every entry to RUN.
  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      wdt_cnt <= WW'(WDT_CYCLES - 1);
    end else if (state != RUN || wdt_kick) begin
      wdt_cnt <= WW'(WDT_CYCLES - 1);
    end else if (wdt_cnt != '0) begin
      wdt_cnt <= wdt_cnt - 1'b1;
    end
  end

  assign wdt_hit = (state == RUN) && (wdt_cnt == '0) && !wdt_kick;
`else
  logic unused_wdt;
  assign unused_wdt = wdt_kick ^ (WDT_CYCLES == 0);
  assign wdt_hit    = 1'b0;
`endif

  assign req_any   = cold_hit | wdt_hit | sw_req;
  assign req_cause = cold_hit ? 2'b01 : (wdt_hit ? 2'b11 : 2'b10);

  // Requests assert resets on the edge they are seen; releases lag state entry by one cycle.
  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      state          <= RST_HOLD;
      counter        <= '0;
      rst_cause      <= 2'b00;
      lock_timeout   <= 1'b0;
      periph_reset_n <= 1'b0;
      cpu_reset_n    <= 1'b0;
      cold_reset_n   <= 1'b0;
      seq_done       <= 1'b0;
    end else if (state != RST_HOLD && req_any) begin
      state          <= RST_HOLD;
      counter        <= '0;
      rst_cause      <= req_cause;
      periph_reset_n <= 1'b0;
      cpu_reset_n    <= 1'b0;
      seq_done       <= 1'b0;
      if (cold_hit) begin
        cold_reset_n <= 1'b0;
      end
    end else begin
      case (state)
        RST_HOLD: begin
          periph_reset_n <= 1'b0;
          cpu_reset_n    <= 1'b0;
          seq_done       <= 1'b0;
          if (cold_hit) begin
            counter      <= '0;
            rst_cause    <= 2'b01;
            cold_reset_n <= 1'b0;
          end else if (counter == CW'(HOLD_CYCLES - 1)) begin
            state   <= WAIT_LOCK;
            counter <= '0;
          end else begin
            counter <= cnt_inc;
          end
        end
        WAIT_LOCK: begin
          if (pll_locked_s) begin
            state        <= REL_PERIPH;
            counter      <= '0;
            lock_timeout <= 1'b0;
          end else if (counter == CW'(LOCK_TIMEOUT - 1)) begin
            state        <= REL_PERIPH;
            counter      <= '0;
            lock_timeout <= 1'b1;
          end else begin
            counter <= cnt_inc;
          end
        end
        REL_PERIPH: begin
          periph_reset_n <= 1'b1;
          cold_reset_n   <= 1'b1;
          if (counter == CW'(PERIPH_TO_CPU - 1)) begin
            state   <= REL_CPU;
            counter <= '0;
          end else begin
            counter <= cnt_inc;
          end
        end
        REL_CPU: begin
          cpu_reset_n <= 1'b1;
          state       <= RUN;
        end
        RUN: begin
          seq_done <= 1'b1;
        end
        default: begin
          state <= RST_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_reset_seq.sv
// Self-checking bench for mfp_reset_seq: vector table with a scoreboard queue, then
// hand-written lock-timeout, cold-request, coincident-request and async-reset sequences.
module tb_mfp_reset_seq;

  localparam int HOLD  = 16;
  localparam int LOCKT = 1024;
  localparam int P2C   = 8;
  localparam int WDT   = 100;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       pll    = 1'b1;
  logic       cold_n = 1'b1;
  logic       sw     = 1'b0;
  logic       kick   = 1'b0;
  logic       periph_reset_n;
  logic       cpu_reset_n;
  logic       cold_reset_n;
  logic [1:0] rst_cause;
  logic       lock_timeout;
  logic       seq_done;

  int checks   = 0;
  int failures = 0;
  logic saw_cause3 = 1'b0;

  // exp = {periph_reset_n, cpu_reset_n, cold_reset_n, rst_cause, lock_timeout, seq_done}
  typedef struct packed {
    logic        rst_n;
    logic        pll;
    logic        cold_n;
    logic        sw;
    logic        kick;
    logic [15:0] cycles;
    logic [6:0]  exp;
  } vec_t;

  vec_t       vecs[12];
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  mfp_reset_seq #(
    .HOLD_CYCLES  (HOLD),
    .LOCK_TIMEOUT (LOCKT),
    .PERIPH_TO_CPU(P2C),
    .WDT_CYCLES   (WDT)
  ) dut (
    .SI_ClkIn      (clk),
    .SI_Reset_N    (rst_n),
    .pll_locked    (pll),
    .cold_req_n    (cold_n),
    .sw_req        (sw),
    .wdt_kick      (kick),
    .periph_reset_n(periph_reset_n),
    .cpu_reset_n   (cpu_reset_n),
    .cold_reset_n  (cold_reset_n),
    .rst_cause     (rst_cause),
    .lock_timeout  (lock_timeout),
    .seq_done      (seq_done)
  );

  always @(negedge clk) begin
    if (rst_cause == 2'b11) saw_cause3 = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_output(input string name);
    logic [6:0] exp;
    logic [6:0] act;
    exp = exp_q.pop_front();
    act = {periph_reset_n, cpu_reset_n, cold_reset_n, rst_cause, lock_timeout, seq_done};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b (periph,cpu,cold,cause,lto,done)", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    rst_n  = v.rst_n;
    pll    = v.pll;
    cold_n = v.cold_n;
    sw     = v.sw;
    kick   = v.kick;
    exp_q.push_back(v.exp);
    tick(int'(v.cycles));
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       pick = periph_reset_n;
      1:       pick = cpu_reset_n;
      default: pick = seq_done;
    endcase
  endfunction

  // Counts edges until the selected output reaches lvl; returns bound on expiry.
  task automatic wait_for(input int sel, input logic lvl, input int bound, output int n);
    n = 0;
    while (pick(sel) !== lvl && n < bound) begin
      tick(1);
      n++;
    end
  endtask

  task automatic pulse_sw();
    sw = 1'b1;
    tick(1);
    sw = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global timeout reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n;
    int drops;
    // Power-up from release edge 1: periph at edge HOLD+2, cpu 8 later, done one after cpu.
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd5,  7'b000_00_0_0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd17, 7'b000_00_0_0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1,  7'b101_00_0_0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd7,  7'b101_00_0_0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1,  7'b111_00_0_0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1,  7'b111_00_0_1};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1,  7'b001_10_0_0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd17, 7'b001_10_0_0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1,  7'b101_10_0_0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd9,  7'b111_10_0_1};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1,  7'b111_10_0_1};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd20, 7'b111_10_0_1};

    #1;
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d", i));
    end

    // Lock never arrives: timeout release HOLD+LOCKT+1 edges after the request.
    pll = 1'b0;
    tick(3);
    pulse_sw();
    check_int("sw cause before timeout", int'(rst_cause), 2);
    wait_for(0, 1'b1, 1200, n);
    check_int("timeout release edge", n, HOLD + LOCKT + 1);
    check_int("lock_timeout set", int'(lock_timeout), 1);
    wait_for(2, 1'b1, 50, n);
    check_int("done after timeout", n, P2C + 1);

    // Relock then software reset: lock_timeout survives the hold, clears on lock.
    pll = 1'b1;
    tick(3);
    pulse_sw();
    check_int("lock_timeout sticky in hold", int'(lock_timeout), 1);
    wait_for(0, 1'b1, 100, n);
    check_int("relock periph edge", n, HOLD + 2);
    check_int("lock_timeout cleared", int'(lock_timeout), 0);
    wait_for(2, 1'b1, 50, n);
    check_int("relock done edge", n, P2C + 1);

    // Cold request timed to land while in REL_CPU.
    pulse_sw();
    wait_for(0, 1'b1, 100, n);
    check_int("pre-cold periph edge", n, HOLD + 2);
    tick(5);
    cold_n = 1'b0;
    tick(2);
    check_int("cpu low entering REL_CPU", int'(cpu_reset_n), 0);
    tick(1);
    exp_q.push_back(7'b000_01_0_0);
    check_output("cold in REL_CPU");
    tick(37);
    exp_q.push_back(7'b000_01_0_0);
    check_output("cold held 40");
    cold_n = 1'b1;
    wait_for(0, 1'b1, 100, n);
    check_int("cold release edge", n, HOLD + 4);
    check_int("cold cause kept", int'(rst_cause), 1);
    wait_for(1, 1'b1, 50, n);
    check_int("cold periph-to-cpu", n, P2C);
    wait_for(2, 1'b1, 10, n);
    check_int("cold done edge", n, 1);

    // Coincident software and cold requests: cold wins once synchronised.
    sw     = 1'b1;
    cold_n = 1'b0;
    tick(1);
    sw = 1'b0;
    check_int("coincident warm first cold_n", int'(cold_reset_n), 1);
    tick(2);
    check_int("coincident cause", int'(rst_cause), 1);
    check_int("coincident cold_reset_n", int'(cold_reset_n), 0);
    cold_n = 1'b1;
    wait_for(0, 1'b1, 100, n);
    check_int("coincident release edge", n, HOLD + 4);
    wait_for(2, 1'b1, 50, n);
    check_int("coincident done edge", n, P2C + 1);

`ifdef MFP_RST_WDT_EN
    pulse_sw();
    wait_for(2, 1'b1, 100, n);
    check_int("wdt pre-seq done", n, HOLD + 2 + P2C + 1);
    wait_for(2, 1'b0, 200, n);
    check_int("wdt expiry edge", n, WDT - 1);
    check_int("wdt cause", int'(rst_cause), 3);
    check_int("wdt warm cold_n", int'(cold_reset_n), 1);
    wait_for(2, 1'b1, 100, n);
    check_int("wdt reseq done", n, HOLD + 2 + P2C + 1);
    drops = 0;
    for (int k = 0; k < 20; k++) begin
      kick = 1'b1;
      tick(1);
      kick = 1'b0;
      if (seq_done !== 1'b1) drops++;
      for (int j = 0; j < 49; j++) begin
        tick(1);
        if (seq_done !== 1'b1) drops++;
      end
    end
    check_int("wdt kicked drops", drops, 0);
`else
    check_int("cause 11 never seen", int'(saw_cause3), 0);
`endif

    // Asynchronous assertion of the board reset mid-cycle.
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(7'b000_00_0_0);
    check_output("async board reset");
    tick(2);
    exp_q.push_back(7'b000_00_0_0);
    check_output("board reset held");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
